// File: rtl/alu_pkg.sv
// Shared opcode encoding for the pipelined ALU.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ADD = 4'd0;
  localparam alu_op_t SUB = 4'd1;
  localparam alu_op_t AND = 4'd2;
  localparam alu_op_t OR  = 4'd3;
  localparam alu_op_t SLT = 4'd4;
  localparam alu_op_t SGT = 4'd5;
  localparam alu_op_t SNE = 4'd6;
  localparam alu_op_t MAX = 4'd7;
  localparam alu_op_t SLL = 4'd8;
  localparam alu_op_t SRL = 4'd9;

  // Highest defined opcode; anything above it is illegal.
  localparam alu_op_t OP_LAST = 4'd9;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus carry/zero/illegal flags.
// Optional macro ALU_OVERFLOW_FLAG_EN adds a signed-overflow output for ADD/SUB.
module alu_core
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  alu_op_t            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHIFT_W-1:0] sh,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               zero,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic               overflow,
`endif
  output logic               illegal
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Both arithmetic forms are kept one bit wider so the top bit is carry/borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Operation select; illegal opcodes fall through to a zero result.
  always_comb begin
    result  = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    case (op)
      ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      AND: result = a & b;
      OR:  result = a | b;
      SLT: result = WIDTH'($signed(a) < $signed(b));
      SGT: result = WIDTH'($signed(a) > $signed(b));
      SNE: result = WIDTH'(a != b);
      MAX: result = (a > b) ? a : b;
      SLL: result = a << sh;
      SRL: result = a >> sh;
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVERFLOW_FLAG_EN
  // Signed overflow: sign of the result disagrees with what the operand signs allow.
  always_comb begin
    overflow = 1'b0;
    case (op)
      ADD: overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      SUB: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: overflow = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// S1 captures the operand set, S2 holds the computed result and flags.
// Optional macro ALU_OVERFLOW_FLAG_EN adds the registered overflowFlag output.
module alu_pipe_param
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHIFT_W-1:0] shiftValue,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carryFlag,
  output logic               zeroFlag,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic               overflowFlag,
`endif
  output logic               illegalOp
);

  logic               s1_valid;
  alu_op_t            s1_op;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [SHIFT_W-1:0] s1_sh;

  logic               advance;
  logic [WIDTH-1:0]   core_result;
  logic               core_carry;
  logic               core_zero;
  logic               core_illegal;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic               core_overflow;
`endif

  // S2 may take a new value when the output slot is empty or being drained;
  // S1 may take a new value when it can hand off to S2 or is empty itself.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance || !s1_valid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (s1_op),
    .a        (s1_a),
    .b        (s1_b),
    .sh       (s1_sh),
    .result   (core_result),
    .carry    (core_carry),
    .zero     (core_zero),
`ifdef ALU_OVERFLOW_FLAG_EN
    .overflow (core_overflow),
`endif
    .illegal  (core_illegal)
  );

  // Stage 1: capture operands on the input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sh    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= opcode;
        s1_a  <= input1;
        s1_b  <= input2;
        s1_sh <= shiftValue;
      end
    end
  end

  // Stage 2: register the core outputs; payload only changes on a real transfer
  // so a stalled result stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryFlag <= 1'b0;
      zeroFlag  <= 1'b0;
      illegalOp <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result    <= core_result;
        carryFlag <= core_carry;
        zeroFlag  <= core_zero;
        illegalOp <= core_illegal;
      end
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  // Overflow flag follows the same S2 load rule as the other flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflowFlag <= 1'b0;
    end else if (advance && s1_valid) begin
      overflowFlag <= core_overflow;
    end
  end
`endif

endmodule
